// File: rtl/branch_predictor_if.sv
// ---------------------------------------------------------------------------
// branch_predictor_if
//   Signal bundle between the pipeline (FD lookup, X-stage training) and the
//   bimodal branch predictor.
//
//   Lookup (FD):   pc_fd, inst_fd -> jump (combinational, same cycle)
//   Training (X):  update_valid qualifies update_pc / update_taken /
//                  update_mispredict; one resolved branch per cycle with
//                  update_valid = 1. There is no ready: the predictor always
//                  accepts. The producer must drop update_valid for flushed
//                  or stalled branches so nothing is counted twice.
//   Control:       clear (synchronous flush of the table)
//   Perf:          branch_cnt, mispredict_cnt
//
//   master: pipeline side (drives lookups and updates)
//   slave:  predictor side
// ---------------------------------------------------------------------------
interface branch_predictor_if;
  logic [31:0] pc_fd;
  logic [31:0] inst_fd;
  logic        jump;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic        update_mispredict;
  logic        clear;
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;

  modport master (
    output pc_fd, inst_fd, update_valid, update_pc, update_taken,
           update_mispredict, clear,
    input  jump, branch_cnt, mispredict_cnt
  );

  modport slave (
    input  pc_fd, inst_fd, update_valid, update_pc, update_taken,
           update_mispredict, clear,
    output jump, branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//   Bimodal predictor: 2**INDEX_W two-bit saturating counters indexed by
//   PC[INDEX_W+1:2]. Predicts taken for conditional branches (opcode 1100011)
//   whose counter MSB is set. Trained by resolved branch outcomes from X.
//   Also counts resolved branches and mispredictions.
//
//   Ports:
//     clk  - clock, all state on rising edge
//     rst  - asynchronous active-high reset
//     bp   - branch_predictor_if.slave (lookup, training, clear, perf counters)
//
//   Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
// ---------------------------------------------------------------------------
module branch_predictor #(
  parameter int INDEX_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  branch_predictor_if.slave   bp
);

  localparam int ENTRIES = 1 << INDEX_W;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [1:0]         r_tbl [ENTRIES];
  logic [31:0]        r_branch_cnt;
  logic [31:0]        r_mispredict_cnt;

  logic [INDEX_W-1:0] w_lk_idx;
  logic [INDEX_W-1:0] w_up_idx;
  logic [1:0]         w_up_ctr;
  logic               w_is_branch;

  assign w_lk_idx    = bp.pc_fd[INDEX_W+1:2];
  assign w_up_idx    = bp.update_pc[INDEX_W+1:2];
  assign w_up_ctr    = r_tbl[w_up_idx];
  assign w_is_branch = (bp.inst_fd[6:0] == OP_BRANCH);

  // Combinational lookup reads the registered table only, so a same-cycle
  // update to the same index is not bypassed.
  assign bp.jump           = w_is_branch && r_tbl[w_lk_idx][1];
  assign bp.branch_cnt     = r_branch_cnt;
  assign bp.mispredict_cnt = r_mispredict_cnt;

  // Table: clear has priority over a concurrent update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) r_tbl[i] <= 2'b01;
    end else if (bp.clear) begin
      for (int i = 0; i < ENTRIES; i++) r_tbl[i] <= 2'b01;
    end else if (bp.update_valid) begin
      if (bp.update_taken) begin
        if (w_up_ctr != 2'b11) r_tbl[w_up_idx] <= w_up_ctr + 2'b01;
      end else begin
        if (w_up_ctr != 2'b00) r_tbl[w_up_idx] <= w_up_ctr - 2'b01;
      end
    end
  end

  // Perf counters ignore clear; they wrap naturally at 32 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else if (bp.update_valid) begin
      r_branch_cnt <= r_branch_cnt + 32'd1;
      if (bp.update_mispredict) r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
    end
  end

  // PC offset bits, bits above the index and the non-opcode instruction
  // field do not influence the prediction.
  logic w_unused;
  assign w_unused = ^{bp.pc_fd[1:0], bp.pc_fd[31:INDEX_W+2],
                      bp.update_pc[1:0], bp.update_pc[31:INDEX_W+2],
                      bp.inst_fd[31:7]};

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Bimodal branch predictor for the fetch/decode (FD) stage of the 4-stage RV32I pipeline. Each cycle it looks up a table of 2-bit saturating counters indexed by the FD PC and drives `jump`, which the PC selector uses to choose between PC+4 and PC+imm for conditional branches. The branch checker in the execute (X) stage writes back each resolved branch outcome to train the table. The block also keeps branch and mispredict counters for performance measurement.

## Interface
Parameters:
- INDEX_W, 4, table index width; ENTRIES = 2**INDEX_W counters; legal range 1..8

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- pc_fd  in  32  PC of the instruction in FD
- inst_fd  in  32  instruction in FD
- jump  out  1  prediction for the FD instruction: 1 = predict taken
- update_valid  in  1  X stage resolved a conditional branch this cycle
- update_pc  in  32  PC of the resolved branch
- update_taken  in  1  actual outcome: 1 = taken
- update_mispredict  in  1  the prediction for this branch was wrong; qualified by update_valid
- clear  in  1  synchronous flush of all prediction state
- branch_cnt  out  32  number of resolved branches
- mispredict_cnt  out  32  number of mispredicted branches

## Operation
- Table: ENTRIES × 2-bit counters. Encoding: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.
- Lookup index = pc_fd[INDEX_W+1:2]. Update index = update_pc[INDEX_W+1:2]. PC bits [1:0] and the bits above the index are ignored, so aliasing is permitted.
- jump = (inst_fd[6:0] == 7'b1100011) && counter[lookup index][1]. This path is combinational from pc_fd, inst_fd, and the table registers. jump is 0 for every non-branch opcode, including JAL and JALR.
- Training, when update_valid = 1:
  - update_taken = 1: the counter increments and saturates at 11.
  - update_taken = 0: the counter decrements and saturates at 00.
  - Only the indexed entry changes.
- Perf counters, when update_valid = 1:
  - branch_cnt increments by 1.
  - mispredict_cnt increments by 1 if update_mispredict = 1.
  - Both are unsigned 32-bit and wrap from 0xFFFFFFFF to 0.
  - update_mispredict is ignored when update_valid = 0.
- clear = 1: every table entry becomes 01 on the next edge. The perf counters are not affected. If clear and update_valid are both 1, clear wins for the table, and the perf counters still count the update.
- The block has no stall input. The upstream stage must deassert update_valid for any branch that is flushed or stalled, so that a single branch is never counted twice.

## Timing
- Reset (asynchronous assert, takes effect immediately):
  - all table entries = 01
  - branch_cnt = 0, mispredict_cnt = 0
  - jump = 0, because every entry is not-taken
- Lookup latency is 0 cycles: jump is valid in the same cycle as pc_fd and inst_fd.
- Update latency is 1 cycle: a counter written at edge N is visible to the lookup from cycle N onward.
- Same-cycle lookup and update of the same index: the lookup returns the pre-update value, with no bypass.
- If rst is asserted during the same cycle as an update, the update is lost and the reset values hold.
- Reset release has no additional latency. Updates are accepted on the first rising edge after rst falls.

## Test plan
- Reset then lookup: assert rst, release it, and present pc_fd = 0x0000_0040 with inst_fd = a BEQ encoding → jump = 0, branch_cnt = 0, mispredict_cnt = 0.
- Training to taken: apply 2 updates with update_pc = 0x40 and update_taken = 1, then look up BEQ at pc_fd = 0x40 → jump = 1. Apply 2 more taken updates, then 1 not-taken update → jump is still 1 (counter 11 → 10).
- Saturation at not-taken: apply 5 not-taken updates at update_pc = 0x80, then 1 taken update → jump = 0 (counter 00 → 01).
- Aliasing and opcode gating (INDEX_W = 4): train PC 0x40 to 11, then look up pc_fd = 0x80 → jump = 1 for a branch opcode. The same PC with a JAL opcode → jump = 0.
- Same-cycle hazard and clear:
  - With entry 0x40 at 01, apply a taken update and a lookup of 0x40 in the same cycle → jump = 0 that cycle and 1 the next cycle.
  - Then assert clear together with an update → all entries return to 01, and branch_cnt increments by 1.
- Counter wrap and mispredict qualification: force branch_cnt = 0xFFFF_FFFF and apply 1 update → branch_cnt = 0. Apply update_mispredict = 1 with update_valid = 0 → mispredict_cnt is unchanged.
